// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write (AW/W/B) and read (AR/R) engines over a
// byte-strobed word array, with FIXED/INCR/WRAP bursts and SLVERR/DECERR reporting.
module axi_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [ADDR_WIDTH-1:0] bytes, total, lower, step;
        bytes = ADDR_WIDTH'(1) << size;
        total = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        lower = addr & ~(total - ADDR_WIDTH'(1));
        step  = addr + bytes;
        case (burst)
            BURST_INCR: next_addr = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            BURST_WRAP: next_addr = (step == lower + total) ? lower : step;
            default:    next_addr = addr;
        endcase
    endfunction

    // Burst-wide legality: reserved type, oversize beats, bad wrap length or alignment.
    function automatic logic is_slverr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [ADDR_WIDTH-1:0] bytes;
        bytes = ADDR_WIDTH'(1) << size;
        is_slverr = (burst == BURST_RSVD) || (int'(size) > OFFS) ||
                    (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                    (burst == BURST_WRAP && (addr & (bytes - ADDR_WIDTH'(1))) != '0);
    endfunction

    function automatic logic is_decerr(input logic [ADDR_WIDTH-1:0] addr);
        is_decerr = {1'b0, addr} >= MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        word_idx = addr[OFFS +: IDX_W];
    endfunction

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst, w_resp;
    logic                  w_slverr;

    logic                  w_fire, w_beat_dec, w_we, w_done;
    logic [1:0]            w_resp_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_fire      = wvalid & wready;
        w_beat_dec  = is_decerr(w_addr);
        w_we        = w_fire & ~w_slverr & ~w_beat_dec;
        w_done      = wlast | (w_cnt == w_len);
        w_resp_next = w_resp;
        if ((wlast != (w_cnt == w_len)) && w_resp_next == RESP_OKAY)
            w_resp_next = RESP_SLVERR;
        if (w_beat_dec)
            w_resp_next = RESP_DECERR;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state  <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            bid      <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_size   <= '0;
            w_burst  <= BURST_FIXED;
            w_resp   <= RESP_OKAY;
            w_slverr <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        bid      <= awid;
                        w_addr   <= awaddr;
                        w_len    <= awlen;
                        w_size   <= awsize;
                        w_burst  <= awburst;
                        w_cnt    <= '0;
                        w_slverr <= is_slverr(awaddr, awsize, awburst, awlen);
                        w_resp   <= is_slverr(awaddr, awsize, awburst, awlen) ? RESP_SLVERR : RESP_OKAY;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_resp <= w_resp_next;
                        w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
                        w_cnt  <= w_cnt + 8'd1;
                        if (w_done) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= w_resp_next;
                            w_state <= W_RESP;
                        end
                    end
                end
                default: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; contents survive aresetn and nothing reads them uninitialised by design.
    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b])
                    mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_slverr;

    logic                  ar_slverr, src_err, src_dec;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] src_data;
    logic [1:0]            src_resp;

    // Source of the beat about to be loaded into the R output registers.
    always_comb begin
        ar_slverr = is_slverr(araddr, arsize, arburst, arlen);
        src_addr  = (r_state == R_IDLE) ? araddr : r_addr;
        src_err   = (r_state == R_IDLE) ? ar_slverr : r_slverr;
        src_dec   = is_decerr(src_addr);
        src_data  = (src_err || src_dec) ? '0 : mem[word_idx(src_addr)];
        src_resp  = src_dec ? RESP_DECERR : (src_err ? RESP_SLVERR : RESP_OKAY);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rid      <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= BURST_FIXED;
            r_slverr <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready  <= 1'b0;
                        rid      <= arid;
                        r_len    <= arlen;
                        r_size   <= arsize;
                        r_burst  <= arburst;
                        r_slverr <= ar_slverr;
                        r_addr   <= next_addr(araddr, arsize, arburst, arlen);
                        r_cnt    <= '0;
                        rvalid   <= 1'b1;
                        rdata    <= src_data;
                        rresp    <= src_resp;
                        rlast    <= (arlen == 8'd0);
                        r_state  <= R_DATA;
                    end
                end
                default: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= next_addr(r_addr, r_size, r_burst, r_len);
                            r_cnt  <= r_cnt + 8'd1;
                            rdata  <= src_data;
                            rresp  <= src_resp;
                            rlast  <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: one task per scenario, inputs driven and
// outputs sampled on the falling edge.
module tb_axi_slave_mem;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [IW-1:0]   awid, bid, arid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] wbuf    [16];
    logic [DW-1:0] rd_data [32];
    logic [1:0]    rd_resp [32];
    logic          rd_last [32];
    logic [IW-1:0] rd_id;

    always #5 aclk = ~aclk;

    axi_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(1024)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input logic [IW-1:0] id, input int nbeats,
                             input int wlast_beat, output logic [1:0] resp, output logic [IW-1:0] id_o);
        int t;
        resp = 2'bxx;
        id_o = 'x;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        if (!awready) begin
            errors++; checks++;
            $display("FAIL aw_timeout: awready=%b required 1", awready);
            awvalid = 1'b0;
            return;
        end
        @(posedge aclk); @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == wlast_beat); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            if (!wready) begin
                errors++; checks++;
                $display("FAIL w_timeout beat %0d: wready=%b required 1", i, wready);
                wvalid = 1'b0;
                return;
            end
            @(posedge aclk); @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_latency: bvalid=%b required 1 one cycle after last W", bvalid);
        end
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        bready = 1'b1;
        resp = bresp;
        id_o = bid;
        @(posedge aclk); @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [IW-1:0] id, input int stall_beat, output int nb);
        int t;
        logic [DW-1:0] s_data;
        logic [1:0]    s_resp;
        logic          s_last;
        logic          done;
        nb = 0;
        done = 1'b0;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        if (!arready) begin
            errors++; checks++;
            $display("FAIL ar_timeout: arready=%b required 1", arready);
            arvalid = 1'b0;
            return;
        end
        @(posedge aclk); @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL r_latency: rvalid=%b required 1 one cycle after AR", rvalid);
        end
        for (int k = 0; k < 64 && !done && nb < 32; k++) begin
            if (!rvalid) begin
                @(negedge aclk);
            end else begin
                if (nb == stall_beat) begin
                    rready = 1'b0;
                    s_data = rdata; s_resp = rresp; s_last = rlast;
                    repeat (5) begin
                        @(negedge aclk);
                        checks++;
                        if (rvalid !== 1'b1 || rdata !== s_data || rresp !== s_resp || rlast !== s_last) begin
                            errors++;
                            $display("FAIL r_stall_stable: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                                     rvalid, rdata, rlast, s_data, s_last);
                        end
                    end
                end
                rready = 1'b1;
                rd_data[nb] = rdata; rd_resp[nb] = rresp; rd_last[nb] = rlast; rd_id = rid;
                done = rlast;
                @(posedge aclk); @(negedge aclk);
                nb++;
            end
        end
        rready = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL r_timeout: no rlast after %0d beats, required %0d", nb, len + 1);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: awr=%b wr=%b bv=%b arr=%b rv=%b rl=%b required all 0",
                     awready, wready, bvalid, arready, rvalid, rlast);
        end
        checks++;
        if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: %h required 0", rdata); end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ready: awready=%b arready=%b wready=%b required 1 1 0", awready, arready, wready);
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp; logic [IW-1:0] id; int nb;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        axi_write(32'h10, 8'd3, 2'd1, 4'hF, 4'd5, 4, 3, resp, id);
        checks++;
        if (resp !== 2'd0 || id !== 4'd5) begin
            errors++; $display("FAIL incr_bresp: bresp=%0d bid=%0d required 0 5", resp, id);
        end
        axi_read(32'h10, 8'd3, 2'd1, 4'd6, -1, nb);
        checks++;
        if (nb !== 4 || rd_id !== 4'd6) begin
            errors++; $display("FAIL incr_rlen: beats=%0d rid=%0d required 4 6", nb, rd_id);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'hA0 + i || rd_resp[i] !== 2'd0 || rd_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL incr_rbeat %0d: rdata=%h rresp=%0d rlast=%b required %h 0 %b",
                         i, rd_data[i], rd_resp[i], rd_last[i], 32'hA0 + i, i == 3);
            end
        end
    endtask

    task automatic test_wrap_read();
        logic [1:0] resp; logic [IW-1:0] id; int nb;
        logic [DW-1:0] exp [4];
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + i;
        axi_write(32'h30, 8'd3, 2'd1, 4'hF, 4'd1, 4, 3, resp, id);
        exp[0] = 32'hC2; exp[1] = 32'hC3; exp[2] = 32'hC0; exp[3] = 32'hC1;
        axi_read(32'h38, 8'd3, 2'd2, 4'd2, -1, nb);
        checks++;
        if (nb !== 4) begin errors++; $display("FAIL wrap_len: beats=%0d required 4", nb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp[i] || rd_resp[i] !== 2'd0) begin
                errors++;
                $display("FAIL wrap_beat %0d: rdata=%h rresp=%0d required %h 0", i, rd_data[i], rd_resp[i], exp[i]);
            end
        end
    endtask

    task automatic test_fixed();
        logic [1:0] resp; logic [IW-1:0] id; int nb;
        for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
        axi_write(32'h20, 8'd3, 2'd0, 4'hF, 4'd3, 4, 3, resp, id);
        axi_read(32'h20, 8'd0, 2'd1, 4'd3, -1, nb);
        checks++;
        if (resp !== 2'd0 || nb !== 1 || rd_data[0] !== 32'h4 || rd_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL fixed: bresp=%0d beats=%0d rdata=%h rlast=%b required 0 1 00000004 1",
                     resp, nb, rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_decerr();
        logic [1:0] resp; logic [IW-1:0] id; int nb;
        wbuf[0] = 32'hDEAD0000; wbuf[1] = 32'hDEAD0001;
        axi_write(32'h0FFC, 8'd1, 2'd1, 4'hF, 4'd7, 2, 1, resp, id);
        checks++;
        if (resp !== 2'd3) begin errors++; $display("FAIL decerr_bresp: %0d required 3", resp); end
        axi_read(32'h0FFC, 8'd0, 2'd1, 4'd7, -1, nb);
        checks++;
        if (rd_data[0] !== 32'hDEAD0000 || rd_resp[0] !== 2'd0) begin
            errors++; $display("FAIL decerr_lastword: rdata=%h rresp=%0d required DEAD0000 0", rd_data[0], rd_resp[0]);
        end
        axi_read(32'h1000, 8'd0, 2'd1, 4'd7, -1, nb);
        checks++;
        if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'd3) begin
            errors++; $display("FAIL decerr_read: rdata=%h rresp=%0d required 0 3", rd_data[0], rd_resp[0]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [IW-1:0] id; int nb;
        wbuf[0] = 32'h11223344;
        axi_write(32'h50, 8'd0, 2'd1, 4'hF, 4'd0, 1, 0, resp, id);
        wbuf[0] = 32'hAABBCCDD;
        axi_write(32'h50, 8'd0, 2'd1, 4'h5, 4'd0, 1, 0, resp, id);
        axi_read(32'h50, 8'd0, 2'd1, 4'd0, -1, nb);
        checks++;
        if (rd_data[0] !== 32'h11BB33DD) begin
            errors++; $display("FAIL strobe: rdata=%h required 11BB33DD", rd_data[0]);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] resp; logic [IW-1:0] id; int nb;
        wbuf[0] = 32'h55550000;
        axi_write(32'h40, 8'd0, 2'd1, 4'hF, 4'd0, 1, 0, resp, id);
        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        axi_write(32'h40, 8'd1, 2'd3, 4'hF, 4'd4, 2, 1, resp, id);
        checks++;
        if (resp !== 2'd2) begin errors++; $display("FAIL rsvd_bresp: %0d required 2", resp); end
        axi_read(32'h40, 8'd0, 2'd1, 4'd0, -1, nb);
        checks++;
        if (rd_data[0] !== 32'h55550000) begin
            errors++; $display("FAIL rsvd_suppress: rdata=%h required 55550000", rd_data[0]);
        end
        axi_read(32'h30, 8'd2, 2'd2, 4'd9, -1, nb);
        checks++;
        if (nb !== 3) begin errors++; $display("FAIL wraplen_beats: %0d required 3", nb); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'd2 || rd_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL wraplen_beat %0d: rdata=%h rresp=%0d rlast=%b required 0 2 %b",
                         i, rd_data[i], rd_resp[i], rd_last[i], i == 2);
            end
        end
    endtask

    task automatic test_wlast_errors();
        logic [1:0] resp; logic [IW-1:0] id;
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        axi_write(32'h70, 8'd3, 2'd1, 4'hF, 4'd2, 2, 1, resp, id);
        checks++;
        if (resp !== 2'd2) begin errors++; $display("FAIL early_wlast: bresp=%0d required 2", resp); end
        axi_write(32'h70, 8'd1, 2'd1, 4'hF, 4'd2, 2, -1, resp, id);
        checks++;
        if (resp !== 2'd2) begin errors++; $display("FAIL missing_wlast: bresp=%0d required 2", resp); end
    endtask

    task automatic test_backpressure();
        int nb;
        axi_read(32'h10, 8'd3, 2'd1, 4'd8, 1, nb);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'hA0 + i || rd_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL bp_beat %0d: rdata=%h rlast=%b required %h %b", i, rd_data[i], rd_last[i], 32'hA0 + i, i == 3);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] resp; logic [IW-1:0] id; int nb; int t; logic saw_b;
        @(negedge aclk);
        awid = 4'd3; awaddr = 32'h60; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        @(posedge aclk); @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wstrb = 4'hF; wlast = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'h99 + i;
            @(posedge aclk); @(negedge aclk);
        end
        wvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid} !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: awr=%b wr=%b bv=%b arr=%b rv=%b required all 0",
                     awready, wready, bvalid, arready, rvalid);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        saw_b = 1'b0;
        repeat (5) begin @(negedge aclk); saw_b = saw_b | bvalid; end
        checks++;
        if (saw_b !== 1'b0) begin errors++; $display("FAIL midreset_no_b: bvalid seen=%b required 0", saw_b); end
        wbuf[0] = 32'h77;
        axi_write(32'h60, 8'd0, 2'd1, 4'hF, 4'd3, 1, 0, resp, id);
        axi_read(32'h60, 8'd0, 2'd1, 4'd3, -1, nb);
        checks++;
        if (resp !== 2'd0 || id !== 4'd3 || rd_data[0] !== 32'h77) begin
            errors++;
            $display("FAIL midreset_recover: bresp=%0d bid=%0d rdata=%h required 0 3 00000077", resp, id, rd_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap_read();
        test_fixed();
        test_decerr();
        test_strobe();
        test_slverr();
        test_wlast_errors();
        test_backpressure();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
